// File: rtl/level_map_scheduler_if.sv
// Map-RAM read port plus the game-logic lookup handshake.
// The scheduler takes the master side: it drives the RAM and answers lookups.
interface level_map_scheduler_if #(
  parameter int ADDR_W = 11
);
  logic [ADDR_W-1:0] mapAddr;
  logic              mapRe;
  logic [2:0]        mapData;
  // Lookup handshake: the requester raises lreq with lcol/lrow and holds all
  // three stable until it sees lack; lack lasts one cycle with ldata valid in
  // that same cycle, and the request may be dropped or replaced right after it.
  logic              lreq;
  logic [4:0]        lcol;
  logic [3:0]        lrow;
  logic              lack;
  logic [2:0]        ldata;

  modport master (
    output mapAddr, mapRe, lack, ldata,
    input  mapData, lreq, lcol, lrow
  );

  modport slave (
    input  mapAddr, mapRe, lack, ldata,
    output mapData, lreq, lcol, lrow
  );
endinterface

// File: rtl/level_map_scheduler.sv
// Shares the single tile-map RAM read port between the per-tile display prefetch
// and game-logic lookups, and produces blockType for the current pixel.
module level_map_scheduler #(
  parameter int         H_OFFSET = 144,
  parameter int         V_OFFSET = 35,
  parameter int         MAP_COLS = 20,
  parameter int         MAP_ROWS = 15,
  parameter int         ADDR_W   = 11,
  parameter logic [2:0] OOB_TYPE = 3'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixEn,
  input  logic       frameStart,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  input  logic [1:0] levelSel,
  output logic [2:0] blockType,
  output logic       dispMiss,
  output logic [1:0] dbgState,
  level_map_scheduler_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2} state_t;

  localparam logic [9:0] H_PRE   = 10'(H_OFFSET - 16);
  localparam logic [9:0] H_FIRST = 10'(H_OFFSET);
  localparam logic [9:0] H_END   = 10'(H_OFFSET + 32 * MAP_COLS);
  localparam logic [9:0] V_FIRST = 10'(V_OFFSET);
  localparam logic [9:0] V_END   = 10'(V_OFFSET + 32 * MAP_ROWS);
  localparam logic [ADDR_W-1:0] LEVEL_SIZE = ADDR_W'(MAP_COLS * MAP_ROWS);
  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(MAP_COLS);

  state_t            state;
  logic              forDisp;
  logic              dispPend;
  logic [4:0]        dispCol;
  logic [3:0]        dispRow;
  logic [2:0]        nextType;
  logic [1:0]        levelReg;

  logic [9:0]        hPre;
  logic [9:0]        hBnd;
  logic [9:0]        vRel;
  logic              vVis;
  logic              preHit;
  logic              bndHit;
  logic              lineEnd;
  logic              offMap;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] dispIdx;
  logic [ADDR_W-1:0] logIdx;

  assign hPre    = hCount - H_PRE;
  assign hBnd    = hCount - H_FIRST;
  assign vRel    = vCount - V_FIRST;
  assign vVis    = (vCount >= V_FIRST) && (vCount < V_END);
  assign lineEnd = (hCount == H_END);

  // Prefetch fires half a tile ahead of each tile boundary on visible lines.
  assign preHit = pixEn && vVis && (hCount >= H_PRE) && (hPre[4:0] == 5'd0)
                  && (hPre[9:5] < 5'(MAP_COLS));
  assign bndHit = (hCount >= H_FIRST) && (hBnd[4:0] == 5'd0)
                  && (hBnd[9:5] < 5'(MAP_COLS));

  assign offMap  = (bus.lcol >= 5'(MAP_COLS)) || (bus.lrow >= 4'(MAP_ROWS));
  assign base    = ADDR_W'(levelReg) * LEVEL_SIZE;
  assign dispIdx = ADDR_W'(dispRow) * COLS_A + ADDR_W'(dispCol);
  assign logIdx  = ADDR_W'(bus.lrow) * COLS_A + ADDR_W'(bus.lcol);

  assign dbgState = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      forDisp     <= 1'b0;
      dispPend    <= 1'b0;
      dispCol     <= '0;
      dispRow     <= '0;
      nextType    <= '0;
      blockType   <= '0;
      levelReg    <= '0;
      dispMiss    <= 1'b0;
      bus.mapAddr <= '0;
      bus.mapRe   <= 1'b0;
      bus.lack    <= 1'b0;
      bus.ldata   <= '0;
    end else begin
      dispMiss <= 1'b0;
      bus.lack <= 1'b0;

      if (frameStart) levelReg <= levelSel;

      if (pixEn) begin
        if (!vVis || lineEnd) begin
          blockType <= '0;
        end else if (bndHit) begin
          // A late fetch keeps the previous tile on screen rather than showing stale data.
          if (dispPend) dispMiss  <= 1'b1;
          else          blockType <= nextType;
        end
      end

      case (state)
        IDLE: begin
          if (dispPend) begin
            bus.mapAddr <= base + dispIdx;
            bus.mapRe   <= 1'b1;
            forDisp     <= 1'b1;
            state       <= ISSUE;
          end else if (bus.lreq && !bus.lack) begin
            // The ack cycle itself still carries the old request, so it is skipped.
            if (offMap) begin
              bus.lack  <= 1'b1;
              bus.ldata <= OOB_TYPE;
            end else begin
              bus.mapAddr <= base + logIdx;
              bus.mapRe   <= 1'b1;
              forDisp     <= 1'b0;
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.mapRe <= 1'b0;
          state     <= CAPTURE;
        end
        CAPTURE: begin
          state <= IDLE;
          if (forDisp) begin
            nextType <= bus.mapData;
            dispPend <= 1'b0;
          end else begin
            bus.ldata <= bus.mapData;
            bus.lack  <= bus.lreq;
          end
        end
        default: state <= IDLE;
      endcase

      // A new prefetch point overrides the clear from a finishing display read.
      if (preHit) begin
        dispPend <= 1'b1;
        dispCol  <= hPre[9:5];
        dispRow  <= 4'(vRel >> 5);
      end
    end
  end

endmodule

// File: tb/tb_level_map_scheduler.sv
// Bench for level_map_scheduler: directed display/lookup sequences, a lookup
// table, and randomized lookups during compressed frame sweeps.
module tb_level_map_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pixEn = 1'b0;
  logic       frameStart = 1'b0;
  logic [9:0] hCount = '0;
  logic [9:0] vCount = '0;
  logic [1:0] levelSel = '0;
  logic [2:0] blockType;
  logic       dispMiss;
  logic [1:0] dbgState;

  level_map_scheduler_if #(.ADDR_W(11)) bus();

  logic       dirReq = 1'b0, rndReq = 1'b0, useRnd = 1'b0;
  logic [4:0] dirCol = '0, rndCol = '0;
  logic [3:0] dirRow = '0, rndRow = '0;

  assign bus.lreq = dirReq | rndReq;
  assign bus.lcol = rndReq ? rndCol : dirCol;
  assign bus.lrow = rndReq ? rndRow : dirRow;

  level_map_scheduler dut (
    .clk(clk), .rst_n(rst_n), .pixEn(pixEn), .frameStart(frameStart),
    .hCount(hCount), .vCount(vCount), .levelSel(levelSel),
    .blockType(blockType), .dispMiss(dispMiss), .dbgState(dbgState),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  logic [2:0] mem [2048];
  always @(posedge clk) if (bus.mapRe) bus.mapData <= mem[bus.mapAddr];

  int tests = 0;
  int failed = 0;
  int missCnt = 0;
  int lackCnt = 0;
  logic prevLack = 1'b0;
  logic [1:0] curLevel = '0;
  logic [10:0] reQ[$];
  logic [2:0] expQ[$];

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic logic [2:0] expData(input logic [1:0] lvl, input int c, input int r);
    if (c >= 20 || r >= 15) return 3'd1;
    return mem[int'(lvl) * 300 + r * 20 + c];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pix(input int h, input int v);
    hCount = 10'(h);
    vCount = 10'(v);
    pixEn  = 1'b1;
    @(negedge clk);
    pixEn  = 1'b0;
  endtask

  task automatic setLevel(input logic [1:0] l);
    levelSel   = l;
    frameStart = 1'b1;
    @(negedge clk);
    frameStart = 1'b0;
    curLevel   = l;
  endtask

  // Raises a lookup at the current negedge and counts cycles until lack.
  task automatic lookup(input int c, input int r, output int lat, output int d);
    dirCol = 5'(c);
    dirRow = 4'(r);
    dirReq = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.lack && lat < 20);
    d = int'(bus.ldata);
    dirReq = 1'b0;
  endtask

  function automatic int reAt(input int i);
    if (reQ.size() > i) return int'(reQ[i]);
    return -1;
  endfunction

  // Bus monitor: read addresses, miss pulses, ack spacing.
  initial forever begin
    @(negedge clk);
    if (bus.mapRe) reQ.push_back(bus.mapAddr);
    if (dispMiss) missCnt++;
    if (bus.lack) begin
      lackCnt++;
      chk("lack_gap", int'(prevLack), 0);
    end
    prevLack = bus.lack;
  end

  // Random requester: keeps lreq high, swapping the tile right after each ack.
  int rndWait = 0;
  task automatic newRnd();
    rndCol  = 5'($urandom_range(0, 21));
    rndRow  = 4'($urandom_range(0, 15));
    rndReq  = 1'b1;
    rndWait = 0;
    expQ.push_back(expData(curLevel, int'(rndCol), int'(rndRow)));
  endtask

  initial forever begin
    @(negedge clk);
    if (rndReq) begin
      if (bus.lack) begin
        chk("rnd_ldata", int'(bus.ldata), (expQ.size() > 0) ? int'(expQ.pop_front()) : -1);
        if (useRnd) newRnd();
        else rndReq = 1'b0;
      end else begin
        rndWait++;
        if (rndWait > 12) begin
          chk("rnd_ack_timeout", rndWait, 0);
          rndReq = 1'b0;
          expQ.delete();
        end
      end
    end else if (useRnd) begin
      newRnd();
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] lvl;
    int col;
    int row;
    bit oob;
    int addr;
  } vec_t;

  vec_t tbl[8];
  int lat, d, lack0, k;

  initial begin
    tbl[0] = '{2'd0, 5, 4, 1'b0, 85};
    tbl[1] = '{2'd2, 2, 2, 1'b0, 642};
    tbl[2] = '{2'd3, 19, 14, 1'b0, 1199};
    tbl[3] = '{2'd1, 0, 0, 1'b0, 300};
    tbl[4] = '{2'd1, 7, 3, 1'b0, 367};
    tbl[5] = '{2'd0, 20, 0, 1'b1, 0};
    tbl[6] = '{2'd2, 0, 15, 1'b1, 0};
    tbl[7] = '{2'd3, 31, 15, 1'b1, 0};

    for (int i = 0; i < 2048; i++) mem[i] = 3'($urandom_range(0, 7));
    mem[0]   = 3'd3;
    mem[1]   = 3'd5;
    mem[642] = 3'd6;

    // Reset state
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("rst_blockType", int'(blockType), 0);
    chk("rst_mapAddr", int'(bus.mapAddr), 0);
    chk("rst_mapRe", int'(bus.mapRe), 0);
    chk("rst_lack", int'(bus.lack), 0);
    chk("rst_ldata", int'(bus.ldata), 0);
    chk("rst_dispMiss", int'(dispMiss), 0);
    chk("rst_state", int'(dbgState), 0);

    // Level 0, first tile of the first line
    setLevel(2'd0);
    idle(2);
    reQ.delete();
    pix(128, 35);
    idle(5);
    chk("disp0_reads", reQ.size(), 1);
    chk("disp0_addr", reAt(0), 0);
    pix(144, 35);
    chk("disp0_blockType", int'(blockType), 3);

    // Boundary reached before the fetch completes
    pix(160, 35);
    pix(176, 35);
    chk("miss_pulse", int'(dispMiss), 1);
    chk("miss_keep", int'(blockType), 3);
    idle(6);
    pix(300, 600);
    chk("offscreen_blank", int'(blockType), 0);

    // Level 2, row 2, col 2
    setLevel(2'd2);
    idle(2);
    reQ.delete();
    pix(192, 99);
    idle(5);
    chk("lvl2_reads", reQ.size(), 1);
    chk("lvl2_addr", reAt(0), 642);
    pix(208, 99);
    chk("lvl2_blockType", int'(blockType), 6);

    // Reset while a logic read is in ISSUE
    dirCol = 5'd3;
    dirRow = 4'd2;
    dirReq = 1'b1;
    idle(1);
    chk("mid_issue_state", int'(dbgState), 1);
    chk("mid_issue_mapRe", int'(bus.mapRe), 1);
    lack0 = lackCnt;
    rst_n  = 1'b0;
    dirReq = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(6);
    chk("rst_abort_lack", lackCnt - lack0, 0);
    chk("rst_abort_state", int'(dbgState), 0);
    chk("rst_abort_blockType", int'(blockType), 0);
    curLevel = 2'd0;
    reQ.delete();
    lookup(5, 4, lat, d);
    chk("post_rst_level_addr", reAt(0), 85);
    chk("post_rst_lat", lat, 3);
    idle(2);

    // Display prefetch and logic request contend in the same IDLE cycle
    reQ.delete();
    pix(160, 35);
    lookup(5, 4, lat, d);
    chk("contend_lat", lat, 6);
    chk("contend_first", reAt(0), 1);
    chk("contend_second", reAt(1), 85);
    chk("contend_ldata", d, int'(mem[85]));
    idle(2);

    // Lookup table
    foreach (tbl[i]) begin
      setLevel(tbl[i].lvl);
      idle(2);
      reQ.delete();
      lookup(tbl[i].col, tbl[i].row, lat, d);
      idle(2);
      chk("tbl_lat", lat, tbl[i].oob ? 1 : 3);
      chk("tbl_ldata", d, tbl[i].oob ? 1 : int'(mem[tbl[i].addr]));
      chk("tbl_reads", reQ.size(), tbl[i].oob ? 0 : 1);
      if (!tbl[i].oob) chk("tbl_addr", reAt(0), tbl[i].addr);
    end

    // Compressed frames with lookups running continuously
    missCnt = 0;
    for (int f = 0; f < 3; f++) begin
      setLevel(2'($urandom_range(0, 3)));
      idle(2);
      useRnd = 1'b1;
      for (int r = 0; r < 15; r++) begin
        for (int s = 0; s < 2; s++) begin
          for (int c = 0; c < 20; c++) begin
            pix(128 + 32 * c, 35 + 32 * r + 31 * s);
            idle(6 + int'($urandom_range(0, 2)));
            pix(144 + 32 * c, 35 + 32 * r + 31 * s);
            chk("sweep_blockType", int'(blockType),
                int'(mem[int'(curLevel) * 300 + r * 20 + c]));
          end
          pix(784, 35 + 32 * r + 31 * s);
          chk("sweep_line_end", int'(blockType), 0);
        end
      end
      useRnd = 1'b0;
      k = 0;
      while (rndReq && k < 50) begin
        idle(1);
        k++;
      end
      chk("sweep_rnd_drained", int'(rndReq), 0);
      chk("sweep_exp_empty", expQ.size(), 0);
      idle(2);
    end
    chk("sweep_no_miss", missCnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
